// File: rtl/nbit_prpg_pkg.sv
// Shared constants for the n-bit pseudo-random pattern generator.
// Holds the maximal-length tap masks for widths 2..16 and a lookup helper.
package nbit_prpg_pkg;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 16;

    // Bit k set means state bit k feeds the XOR. Index is the LFSR width.
    // Entries 0 and 1 are unused.
    localparam logic [N_MAX:0][N_MAX-1:0] TAP_TABLE = {
        16'hD008,  // 16: x^16+x^15+x^13+x^4+1
        16'h6000,  // 15: x^15+x^14+1
        16'h2015,  // 14: x^14+x^5+x^3+x^1+1
        16'h100D,  // 13: x^13+x^4+x^3+x^1+1
        16'h0829,  // 12: x^12+x^6+x^4+x^1+1
        16'h0500,  // 11: x^11+x^9+1
        16'h0240,  // 10: x^10+x^7+1
        16'h0110,  //  9: x^9+x^5+1
        16'h00B8,  //  8: x^8+x^6+x^5+x^4+1
        16'h0060,  //  7: x^7+x^6+1
        16'h0030,  //  6: x^6+x^5+1
        16'h0014,  //  5: x^5+x^3+1
        16'h000C,  //  4: x^4+x^3+1
        16'h0006,  //  3: x^3+x^2+1
        16'h0003,  //  2: x^2+x+1
        16'h0000,
        16'h0000
    };

    function automatic logic [N_MAX-1:0] tap_mask(input int unsigned width);
        if (width < N_MIN || width > N_MAX) begin
            return '0;
        end
        return TAP_TABLE[width[4:0]];
    endfunction

endpackage

// File: rtl/prpg_lfsr_core.sv
// Fibonacci LFSR core: n-bit shift-left register with XOR feedback into bit 0.
// load has priority over step; reset is synchronous and active-high.
module prpg_lfsr_core
    import nbit_prpg_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [n-1:0] load_val,
    output logic [n-1:0] state
);

    localparam logic [N_MAX-1:0] TAPS = tap_mask(n);

    logic [n-1:0] state_q;
    logic         fb;

    assign fb    = ^(state_q & TAPS[n-1:0]);
    assign state = state_q;

    // Shift register: clear, load, or advance one step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= load_val;
        end else if (step) begin
            state_q <= {state_q[n-2:0], fb};
        end
    end

endmodule

// File: rtl/nbit_prpg.sv
// n-bit pseudo-random pattern generator (maximal-length Fibonacci LFSR).
// Outputs: parallel state num, serial bit sequence_bit (= num[n-1]),
// step counter count (0..2^n-2) and valid.
// Optional macro PRPG_PERIOD_FLAG_EN adds period_done, a one-cycle pulse on
// the edge where count wraps back to 0 (LFSR back at its loaded seed).
module nbit_prpg
    import nbit_prpg_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] seed,
    input  logic         load,
`ifdef PRPG_PERIOD_FLAG_EN
    output logic         period_done,
`endif
    output logic [n-1:0] count,
    output logic [n-1:0] num,
    output logic         sequence_bit,
    output logic         valid
);

    if (n < N_MIN || n > N_MAX) begin : g_bad_width
        $error("nbit_prpg: parameter n must be in 2..16");
    end

    localparam int unsigned CntMaxInt = (1 << n) - 2;
    localparam logic [n-1:0] CNT_MAX  = CntMaxInt[n-1:0];

    logic [n-1:0] count_q;
    logic         valid_q;
    logic         step;
    logic         wrap;
    logic [n-1:0] seed_fixed;

    // An all-zero seed would lock the LFSR, so substitute 1.
    assign seed_fixed = (seed == '0) ? {{(n-1){1'b0}}, 1'b1} : seed;
    assign step       = valid_q & ~load;
    assign wrap       = step & (count_q == CNT_MAX);

    prpg_lfsr_core #(
        .n (n)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .load_val (seed_fixed),
        .state    (num)
    );

    // Step counter and valid flag, tracking the LFSR period.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            count_q <= '0;
            valid_q <= 1'b1;
        end else if (step) begin
            count_q <= wrap ? '0 : count_q + 1'b1;
        end
    end

`ifdef PRPG_PERIOD_FLAG_EN
    logic period_done_q;

    // Single-cycle pulse registered on the wrap edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_done_q <= 1'b0;
        end else begin
            period_done_q <= wrap;
        end
    end

    assign period_done = period_done_q;
`endif

    assign count        = count_q;
    assign valid        = valid_q;
    assign sequence_bit = num[n-1];

endmodule

// File: tb/tb_nbit_prpg.sv
// Self-checking bench for nbit_prpg at n=4. Table-driven vectors go through
// a scoreboard queue; hand-written sequences cover random seeds and the
// optional period flag (PRPG_PERIOD_FLAG_EN).
module tb_nbit_prpg;

    localparam int unsigned W = 4;

    typedef struct {
        logic         rst;
        logic         ld;
        logic [W-1:0] seed;
        logic [W-1:0] e_num;
        logic [W-1:0] e_cnt;
        logic         e_val;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] seed;
    logic         load;
    logic [W-1:0] count;
    logic [W-1:0] num;
    logic         sequence_bit;
    logic         valid;
`ifdef PRPG_PERIOD_FLAG_EN
    logic         period_done;
`endif

    int n_pass  = 0;
    int n_total = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    nbit_prpg #(
        .n (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seed         (seed),
        .load         (load),
`ifdef PRPG_PERIOD_FLAG_EN
        .period_done  (period_done),
`endif
        .count        (count),
        .num          (num),
        .sequence_bit (sequence_bit),
        .valid        (valid)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic [W-1:0] s,
                       input logic [W-1:0] en, input logic [W-1:0] ec, input logic ev);
        vec_t v;
        v.rst = r; v.ld = l; v.seed = s; v.e_num = en; v.e_cnt = ec; v.e_val = ev;
        tbl.push_back(v);
    endtask

    // Drive one vector, push its expectation, sample just after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        reset = v.rst;
        load  = v.ld;
        seed  = v.seed;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " num"},   int'(num),          int'(e.e_num));
        check({tag, " count"}, int'(count),        int'(e.e_cnt));
        check({tag, " valid"}, int'(valid),        int'(e.e_val));
        check({tag, " seq"},   int'(sequence_bit), int'(e.e_num[W-1]));
    endtask

    initial begin
        logic [W-1:0] run_nums [15];
        logic [W-1:0] rseed;
        reset = 1'b1;
        load  = 1'b0;
        seed  = '0;
        run_nums = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                     4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

        // Reset (with load and seed asserted: reset wins), then idle.
        add(1, 1, 4'hF, 4'h0, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 0);
        add(0, 0, 4'hF, 4'h0, 0, 0);
        // Load 1111 and run a full period.
        add(0, 1, 4'hF, 4'hF, 0, 1);
        for (int i = 0; i < 15; i++) begin
            add(0, 0, 4'h0, run_nums[i], (i == 14) ? 4'd0 : 4'(i + 1), 1);
        end
        // Held load re-loads every cycle.
        for (int i = 0; i < 5; i++) add(0, 1, 4'hA, 4'hA, 0, 1);
        // Zero seed is replaced by 0001.
        add(0, 1, 4'h0, 4'h1, 0, 1);
        add(0, 0, 4'h0, 4'h2, 1, 1);
        add(0, 0, 4'h0, 4'h4, 2, 1);
        // Reset after 7 steps, then hold, then clean restart.
        add(0, 1, 4'hF, 4'hF, 0, 1);
        for (int i = 0; i < 7; i++) add(0, 0, 4'h0, run_nums[i], 4'(i + 1), 1);
        add(1, 0, 4'h0, 4'h0, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0, 0);
        add(0, 0, 4'h0, 4'h0, 0, 0);
        add(0, 1, 4'h5, 4'h5, 0, 1);
        add(0, 0, 4'h0, 4'hB, 1, 1);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Random non-zero seeds: never zero, returns to seed after 15 steps.
        for (int r = 0; r < 3; r++) begin
            rseed = 4'($urandom_range(1, 15));
            @(negedge clk);
            load = 1'b1;
            seed = rseed;
            @(negedge clk);
            load = 1'b0;
            for (int k = 1; k <= 15; k++) begin
                @(posedge clk);
                #1;
                if (num == '0) check("rand nonzero", int'(num), 1);
                if (k == 15) begin
                    check("rand period num",   int'(num),   int'(rseed));
                    check("rand period count", int'(count), 0);
                end
            end
        end

`ifdef PRPG_PERIOD_FLAG_EN
        // period_done pulses only on the wrap steps (15 and 30).
        @(negedge clk);
        load = 1'b1;
        seed = 4'hF;
        @(posedge clk);
        #1;
        check("pd after load", int'(period_done), 0);
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pd step%0d", k), int'(period_done),
                  (k == 15 || k == 30) ? 1 : 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("pd reset", int'(period_done), 0);
`endif

        if (sb.size() != 0) check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
